// File: rtl/shseq_pkg.sv
// Shared types for the shift operand sequencer: FSM states,
// instruction class codes and register field positions.
package shseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_RM,
    CAP_RM,
    RD_RS,
    CAP_RS,
    SHIFT,
    DONE
  } state_e;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  localparam int RM_LSB       = 0;
  localparam int RS_LSB       = 8;
  localparam int REGSHIFT_BIT = 4;

endpackage

// File: rtl/shift_op_sequencer.sv
// Sequences one operand-2 through the external barrel shifter.
// Ports: instr valid/ready in, RF read port, sh_* to shifter,
// res_* valid/ready out. Optional SHSEQ_PC_OPERAND_EN adds
// pc_plus8 and substitutes it for R15 without an RF read.
module shift_op_sequencer
  import shseq_pkg::*;
#(
  parameter int RF_AW = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             carry_in,
  output logic             rf_rd_en,
  output logic [RF_AW-1:0] rf_rd_addr,
  input  logic [DW-1:0]    rf_rd_data,
`ifdef SHSEQ_PC_OPERAND_EN
  input  logic [DW-1:0]    pc_plus8,
`endif
  output logic [31:0]      sh_ir,
  output logic [DW-1:0]    sh_rm,
  output logic [DW-1:0]    sh_rs,
  output logic             sh_carry_in,
  input  logic [DW-1:0]    sh_out,
  input  logic             sh_carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             res_carry,
  output logic             res_bypass
);

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic            c_q, c_d;
  logic [DW-1:0]   rm_q, rm_d;
  logic [DW-1:0]   rs_q, rs_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            rcar_q, rcar_d;
  logic            rbyp_q, rbyp_d;

  logic [RF_AW-1:0] rm_addr, rs_addr;
  logic             rm_pc, rs_pc;
  logic [DW-1:0]    rm_src, rs_src;

  assign rm_addr = RF_AW'(ir_q[RM_LSB +: 4]);
  assign rs_addr = RF_AW'(ir_q[RS_LSB +: 4]);

`ifdef SHSEQ_PC_OPERAND_EN
  // R15 comes from pc_plus8; the read slot is kept so
  // latency matches the RF path.
  assign rm_pc  = &ir_q[RM_LSB +: 4];
  assign rs_pc  = &ir_q[RS_LSB +: 4];
  assign rm_src = rm_pc ? pc_plus8 : rf_rd_data;
  assign rs_src = rs_pc ? pc_plus8 : rf_rd_data;
`else
  assign rm_pc  = 1'b0;
  assign rs_pc  = 1'b0;
  assign rm_src = rf_rd_data;
  assign rs_src = rf_rd_data;
`endif

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    c_d         = c_q;
    rm_d        = rm_q;
    rs_d        = rs_q;
    rdat_d      = rdat_q;
    rcar_d      = rcar_q;
    rbyp_d      = rbyp_q;
    instr_ready = 1'b0;
    rf_rd_en    = 1'b0;
    rf_rd_addr  = '0;
    res_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && !flush) begin
          ir_d = instr;
          c_d  = carry_in;
          rm_d = '0;
          rs_d = '0;
          unique case (1'b1)
            instr[27:25] == CLS_DP_REG:
              state_d = RD_RM;
            instr[27:25] == CLS_DP_IMM:
              state_d = SHIFT;
            default: begin
              state_d = DONE;
              rdat_d  = '0;
              rcar_d  = carry_in;
              rbyp_d  = 1'b1;
            end
          endcase
        end
      end
      RD_RM: begin
        rf_rd_en   = !rm_pc;
        rf_rd_addr = rm_addr;
        state_d    = ir_q[REGSHIFT_BIT] ? RD_RS : CAP_RM;
      end
      CAP_RM: begin
        rm_d    = rm_src;
        rs_d    = '0;
        state_d = SHIFT;
      end
      // Rm data returns here while Rs is requested.
      RD_RS: begin
        rm_d       = rm_src;
        rf_rd_en   = !rs_pc;
        rf_rd_addr = rs_addr;
        state_d    = CAP_RS;
      end
      CAP_RS: begin
        rs_d    = rs_src;
        state_d = SHIFT;
      end
      SHIFT: begin
        rdat_d  = sh_out;
        rcar_d  = sh_carry_out;
        rbyp_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      rdat_d  = '0;
      rcar_d  = 1'b0;
      rbyp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      c_q     <= 1'b0;
      rm_q    <= '0;
      rs_q    <= '0;
      rdat_q  <= '0;
      rcar_q  <= 1'b0;
      rbyp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      rm_q    <= rm_d;
      rs_q    <= rs_d;
      rdat_q  <= rdat_d;
      rcar_q  <= rcar_d;
      rbyp_q  <= rbyp_d;
    end
  end

  assign sh_ir       = ir_q;
  assign sh_rm       = rm_q;
  assign sh_rs       = rs_q;
  assign sh_carry_in = c_q;
  assign res_data    = rdat_q;
  assign res_carry   = rcar_q;
  assign res_bypass  = rbyp_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Scoreboard bench for shift_op_sequencer with a behavioural
// barrel shifter and a one-cycle-latency register file.
module tb_shift_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        carry_in;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [31:0] pc_plus8;
  logic [31:0] sh_ir, sh_rm, sh_rs;
  logic        sh_carry_in;
  logic [31:0] sh_out;
  logic        sh_carry_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_carry;
  logic        res_bypass;

  always #5 clk = ~clk;

  shift_op_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .carry_in     (carry_in),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
`ifdef SHSEQ_PC_OPERAND_EN
    .pc_plus8     (pc_plus8),
`endif
    .sh_ir        (sh_ir),
    .sh_rm        (sh_rm),
    .sh_rs        (sh_rs),
    .sh_carry_in  (sh_carry_in),
    .sh_out       (sh_out),
    .sh_carry_out (sh_carry_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_bypass   (res_bypass)
  );

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        bypass;
    int          lat;
    logic [31:0] ir;
    logic [31:0] rs;
  } exp_t;

  exp_t        sbq[$];
  logic [3:0]  rdlog[$];
  int          rdcyc[$];
  logic [31:0] rf[16];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          nvec = 0;
  int          nbad = 0;

  // Behavioural shifter (ARM operand-2 subset).
  int          amt;
  logic [31:0] v;
  always_comb begin
    sh_out       = 32'h0;
    sh_carry_out = sh_carry_in;
    amt          = 0;
    v            = 32'h0;
    if (sh_ir[27:25] == 3'b001) begin
      amt = 2 * int'(sh_ir[11:8]);
      v   = {24'h0, sh_ir[7:0]};
      if (amt == 0) sh_out = v;
      else begin
        sh_out       = (v >> amt) | (v << (32 - amt));
        sh_carry_out = sh_out[31];
      end
    end else begin
      amt = sh_ir[4] ? int'(sh_rs[7:0]) : int'(sh_ir[11:7]);
      v   = sh_rm;
      if (amt == 0) sh_out = v;
      else if (amt < 32) begin
        case (sh_ir[6:5])
          2'd0: begin
            sh_out       = v << amt;
            sh_carry_out = v[32-amt];
          end
          2'd1: begin
            sh_out       = v >> amt;
            sh_carry_out = v[amt-1];
          end
          2'd2: begin
            sh_out       = 32'($signed(v) >>> amt);
            sh_carry_out = v[amt-1];
          end
          default: begin
            sh_out       = (v >> amt) | (v << (32 - amt));
            sh_carry_out = v[amt-1];
          end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && rf_rd_en) begin
      rf_rd_data <= rf[rf_rd_addr];
      rdlog.push_back(rf_rd_addr);
      rdcyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare on each new result presentation.
  bit   seen = 0;
  exp_t me;
  always @(negedge clk) begin
    if (res_valid && !seen) begin
      seen = 1;
      if (sbq.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_result: got %h expected none",
                 res_data);
      end else begin
        me = sbq.pop_front();
        chk("res_data", res_data, me.data);
        chk("res_carry", res_carry, me.carry);
        chk("res_bypass", res_bypass, me.bypass);
        chk("latency", cyc - acc_cyc + 1, me.lat);
        chk("sh_ir", sh_ir, me.ir);
        chk("sh_rs", sh_rs, me.rs);
      end
    end
    if (!res_valid) seen = 0;
  end

  task automatic issue(input logic [31:0] ir, input logic c,
                       input logic [31:0] ed, input logic ec,
                       input logic eb, input int el,
                       input logic [31:0] ers, input int nrd,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input int hold);
    exp_t e;
    bit   got;
    e.data = ed; e.carry = ec; e.bypass = eb;
    e.lat = el; e.ir = ir; e.rs = ers;
    sbq.push_back(e);
    rdlog.delete();
    rdcyc.delete();
    res_ready = (hold == 0);
    @(negedge clk);
    chk("rdy_idle", instr_ready, 1);
    instr = ir; carry_in = c; instr_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    instr_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    if (!got) begin
      nvec++;
      nbad++;
      $display("FAIL timeout: got no res_valid expected one");
      void'(sbq.pop_front());
    end else begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, ed);
        chk("hold_carry", res_carry, ec);
        chk("hold_rdy", instr_ready, 0);
        @(negedge clk);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_valid", res_valid, 0);
      chk("post_rdy", instr_ready, 1);
      chk("n_reads", rdlog.size(), nrd);
      if (nrd >= 1 && rdlog.size() >= 1)
        chk("rd_addr0", rdlog[0], a0);
      if (nrd >= 2 && rdlog.size() >= 2) begin
        chk("rd_addr1", rdlog[1], a1);
        chk("rd_consec", rdcyc[1] - rdcyc[0], 1);
      end
    end
    res_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[1]  = 32'h0000_0003;
    rf[15] = 32'hDEAD_BEEF;
    rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    instr = 32'h0; carry_in = 1'b0; res_ready = 1'b1;
    pc_plus8 = 32'h0000_1008; rf_rd_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", instr_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_rden", rf_rd_en, 0);
    chk("rst_shir", sh_ir, 0);
    chk("rst_data", res_data, 0);
    rst_n = 1'b1;

    issue(32'hE3A002FF, 0, 32'hF000000F, 1, 0, 2, 0, 0, 0, 0, 0);
    issue(32'hE1A00101, 0, 32'h0000000C, 0, 0, 4, 0, 1, 1, 0, 0);
    rf[1] = 32'h8000_0000;
    rf[2] = 32'h0000_0004;
    issue(32'hE1A00231, 1, 32'h08000000, 0, 0, 5, 4, 2, 1, 2, 0);
    issue(32'hEA000010, 1, 32'h0, 1, 1, 1, 0, 0, 0, 0, 0);
    issue(32'hE5900000, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0);
    issue(32'hE3A002FF, 1, 32'hF000000F, 1, 0, 2, 0, 0, 0, 0, 6);
`ifdef SHSEQ_PC_OPERAND_EN
    issue(32'hE1A0000F, 1, 32'h00001008, 1, 0, 4, 0, 0, 0, 0, 0);
`else
    issue(32'hE1A0000F, 1, 32'hDEADBEEF, 1, 0, 4, 0, 1, 15, 0, 0);
`endif

    // Flush while in RD_RS; an offered branch must be ignored.
    @(negedge clk);
    chk("fl_rdy", instr_ready, 1);
    instr = 32'hE1A00231; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_rden", rf_rd_en, 1);
    chk("fl_addr", rf_rd_addr, 2);
    flush = 1'b1; instr = 32'hEA000010; instr_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; instr_valid = 1'b0;
    chk("fl_idle", instr_ready, 1);
    chk("fl_valid", res_valid, 0);
    repeat (6) @(negedge clk);
    chk("fl_quiet", res_valid, 0);

    // Asynchronous reset during SHIFT.
    @(negedge clk);
    instr = 32'hE3A002FF; instr_valid = 1'b1; carry_in = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", res_valid, 0);
    chk("ar_rdy", instr_ready, 1);
    chk("ar_shir", sh_ir, 0);
    chk("ar_cin", sh_carry_in, 0);
    chk("ar_data", res_data, 0);
    chk("ar_rden", rf_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_quiet", res_valid, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
